// File: rtl/bitwise_logic_pkg.sv
// Shared op codes, base-op encoding and FSM states for bitwise_logic_unit.
// Decode helpers split a 3-bit op into a base operation and an invert flag.
package bitwise_logic_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    BASE_AND  = 2'd0,
    BASE_OR   = 2'd1,
    BASE_XOR  = 2'd2,
    BASE_PASS = 2'd3
  } base_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  function automatic base_e op_base(input logic [2:0] op);
    case (op)
      OP_AND,  OP_NAND: op_base = BASE_AND;
      OP_OR,   OP_NOR:  op_base = BASE_OR;
      OP_XOR,  OP_XNOR: op_base = BASE_XOR;
      default:          op_base = BASE_PASS;
    endcase
  endfunction

  function automatic logic op_inv(input logic [2:0] op);
    op_inv = (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR) || (op == OP_NOT_A);
  endfunction

endpackage

// File: rtl/bitwise_core.sv
// Combinational base operation; PASS forwards operand a.
// Shared by the per-beat operation and the accumulate fold.
module bitwise_core
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  base_e            base,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = a;
    case (base)
      BASE_AND:  r = a & b;
      BASE_OR:   r = a | b;
      BASE_XOR:  r = a ^ b;
      default:   r = a;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered WIDTH-bit logic stage with valid/ready on both sides.
// Define BITWISE_LOGIC_UNIT_ACC_EN to build packet-accumulate mode.
module bitwise_logic_unit
  import bitwise_logic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int BEAT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [2:0]        in_op,
  input  logic              in_acc,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_y,
  output logic              out_zero,
  output logic              out_ones,
  output logic [BEAT_W-1:0] out_beats
);

  logic              w_accept;
  base_e             w_beat_base;
  logic [WIDTH-1:0]  w_r;
  logic              w_load;
  logic [WIDTH-1:0]  w_res;
  logic [BEAT_W-1:0] w_beats_ld;

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_y;
  logic              r_zero;
  logic              r_ones;
  logic [BEAT_W-1:0] r_beats_out;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  bitwise_core #(.WIDTH(WIDTH)) u_beat (
    .a    (in_a),
    .b    (in_b),
    .base (w_beat_base),
    .r    (w_r)
  );

`ifdef BITWISE_LOGIC_UNIT_ACC_EN
  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_acc, w_acc_nxt, w_fold;
  base_e             r_base, w_base_nxt;
  logic              r_inv, w_inv_nxt;
  logic [BEAT_W-1:0] r_beats, w_beats_nxt, w_beats_inc;

  // Mid-packet beats use the op latched on the first beat.
  assign w_beat_base = (r_state == ST_ACC) ? r_base : op_base(in_op);
  assign w_beats_inc = (r_beats == {BEAT_W{1'b1}}) ? r_beats : r_beats + BEAT_W'(1);

  // Operands swapped so BASE_PASS yields the newest beat.
  bitwise_core #(.WIDTH(WIDTH)) u_fold (
    .a    (w_r),
    .b    (r_acc),
    .base (r_base),
    .r    (w_fold)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_base  <= BASE_AND;
      r_inv   <= 1'b0;
      r_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_base  <= w_base_nxt;
      r_inv   <= w_inv_nxt;
      r_beats <= w_beats_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_base_nxt  = r_base;
    w_inv_nxt   = r_inv;
    w_beats_nxt = r_beats;
    w_load      = 1'b0;
    w_res       = '0;
    w_beats_ld  = '0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (in_acc && !in_last) begin
            w_state_nxt = ST_ACC;
            w_acc_nxt   = w_r;
            w_base_nxt  = op_base(in_op);
            w_inv_nxt   = op_inv(in_op);
            w_beats_nxt = BEAT_W'(1);
          end else begin
            w_load     = 1'b1;
            w_res      = op_inv(in_op) ? ~w_r : w_r;
            w_beats_ld = BEAT_W'(1);
          end
        end
        default: begin
          if (in_last) begin
            w_state_nxt = ST_IDLE;
            w_acc_nxt   = '0;
            w_beats_nxt = '0;
            w_load      = 1'b1;
            w_res       = r_inv ? ~w_fold : w_fold;
            w_beats_ld  = w_beats_inc;
          end else begin
            w_acc_nxt   = w_fold;
            w_beats_nxt = w_beats_inc;
          end
        end
      endcase
    end
  end
`else
  logic w_unused;
  assign w_unused    = in_acc ^ in_last;
  assign w_beat_base = op_base(in_op);

  always_comb begin
    w_load     = w_accept;
    w_res      = op_inv(in_op) ? ~w_r : w_r;
    w_beats_ld = BEAT_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_ones      <= 1'b0;
      r_beats_out <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_y         <= w_res;
      r_zero      <= (w_res == '0);
      r_ones      <= (&w_res);
      r_beats_out <= w_beats_ld;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_y     = r_y;
  assign out_zero  = r_zero;
  assign out_ones  = r_ones;
  assign out_beats = r_beats_out;

endmodule
